// File: rtl/pcie_msi_irq_ctrl_if.sv
// Configuration-space MSI bus between the interrupt controller and the PCIe hard IP.
// The master side is the controller; the slave side is the IP.
interface pcie_msi_irq_ctrl_if;
   logic [3:0]  cfg_interrupt_msi_enable;
   logic [11:0] cfg_interrupt_msi_mmenable;
   logic [31:0] cfg_interrupt_msi_int;
   logic        cfg_interrupt_msi_sent;
   logic        cfg_interrupt_msi_fail;
   logic [3:0]  cfg_interrupt_msi_select;
   logic [3:0]  cfg_interrupt_msi_function_number;
   logic [2:0]  cfg_interrupt_msi_attr;
   logic        cfg_interrupt_msi_tph_present;
   logic [1:0]  cfg_interrupt_msi_tph_type;
   logic [8:0]  cfg_interrupt_msi_tph_st_tag;
   logic [31:0] cfg_interrupt_msi_pending_status;
   logic        cfg_interrupt_msi_pending_status_data_enable;
   logic [3:0]  cfg_interrupt_msi_pending_status_function_num;

   modport master (
      input  cfg_interrupt_msi_enable,
      input  cfg_interrupt_msi_mmenable,
      input  cfg_interrupt_msi_sent,
      input  cfg_interrupt_msi_fail,
      output cfg_interrupt_msi_int,
      output cfg_interrupt_msi_select,
      output cfg_interrupt_msi_function_number,
      output cfg_interrupt_msi_attr,
      output cfg_interrupt_msi_tph_present,
      output cfg_interrupt_msi_tph_type,
      output cfg_interrupt_msi_tph_st_tag,
      output cfg_interrupt_msi_pending_status,
      output cfg_interrupt_msi_pending_status_data_enable,
      output cfg_interrupt_msi_pending_status_function_num
   );

   modport slave (
      output cfg_interrupt_msi_enable,
      output cfg_interrupt_msi_mmenable,
      output cfg_interrupt_msi_sent,
      output cfg_interrupt_msi_fail,
      input  cfg_interrupt_msi_int,
      input  cfg_interrupt_msi_select,
      input  cfg_interrupt_msi_function_number,
      input  cfg_interrupt_msi_attr,
      input  cfg_interrupt_msi_tph_present,
      input  cfg_interrupt_msi_tph_type,
      input  cfg_interrupt_msi_tph_st_tag,
      input  cfg_interrupt_msi_pending_status,
      input  cfg_interrupt_msi_pending_status_data_enable,
      input  cfg_interrupt_msi_pending_status_function_num
   );
endinterface

// File: rtl/pcie_msi_irq_ctrl.sv
// Round-robin MSI issuer with pending latch, vector folding and outcome tracking.
// Define MSI_FAIL_RETRY_EN to keep a vector pending after fail/timeout.
module pcie_msi_irq_ctrl #(
   parameter int MSI_COUNT = 32,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MSI_COUNT-1:0] irq_in_i,
   pcie_msi_irq_ctrl_if.master  msi,
   output logic [15:0]          stat_sent_count_o,
   output logic [15:0]          stat_fail_count_o
);
   localparam int IW = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

   state_e               state_q, state_d;
   logic [MSI_COUNT-1:0] pend_q, pend_d;
   logic [IW-1:0]        cur_q, cur_d;
   logic [IW-1:0]        last_q, last_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic                 rereq_q, rereq_d;
   logic [31:0]          ps_q, ps_d;
   logic                 de_q, de_d;
   logic [15:0]          sent_cnt_q, sent_cnt_d;
   logic [15:0]          fail_cnt_q, fail_cnt_d;

   logic                 sel_found;
   logic [IW-1:0]        sel_idx;
   logic [2:0]           mm;
   logic [4:0]           mask;
   logic [4:0]           v_eff;
   logic                 rereq_now;
   logic                 ack_sent;
   logic                 ack_fail;

   // First pending index strictly after last_grant, wrapping around
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= MSI_COUNT; k++) begin
         idx = (int'(last_q) + k) % MSI_COUNT;
         if (!sel_found && pend_q[idx]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(idx);
         end
      end
   end

   assign mm    = (msi.cfg_interrupt_msi_mmenable[2:0] > 3'd5) ?
                  3'd5 : msi.cfg_interrupt_msi_mmenable[2:0];
   assign mask  = 5'((6'd1 << mm) - 6'd1);
   assign v_eff = 5'(cur_q) & mask;

   assign rereq_now = rereq_q | irq_in_i[cur_q];
   assign ack_sent  = (state_q == S_WAIT) && msi.cfg_interrupt_msi_sent;
   assign ack_fail  = (state_q == S_WAIT) && !msi.cfg_interrupt_msi_sent &&
                      (msi.cfg_interrupt_msi_fail || (tmr_q == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (msi.cfg_interrupt_msi_enable[0] && sel_found)
                     state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (ack_sent || ack_fail) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      msi.cfg_interrupt_msi_int = '0;
      if (state_q == S_ISSUE)
         msi.cfg_interrupt_msi_int = 32'd1 << v_eff;
   end

   always_comb begin
      pend_d     = pend_q | irq_in_i;
      cur_d      = cur_q;
      last_d     = last_q;
      tmr_d      = tmr_q;
      rereq_d    = 1'b0;
      sent_cnt_d = sent_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if (state_q == S_IDLE && state_d == S_ISSUE) cur_d = sel_idx;
      if (state_q != S_IDLE) rereq_d = rereq_now;
      if (state_q == S_ISSUE) tmr_d = TW'(TIMEOUT - 1);
      if (state_q == S_WAIT && tmr_q != '0) tmr_d = tmr_q - 1'b1;
      // A re-request seen during the issue keeps the vector pending
      if (ack_sent) begin
         if (!rereq_now) pend_d[cur_q] = 1'b0;
         last_d     = cur_q;
         sent_cnt_d = sent_cnt_q + 16'(sent_cnt_q != 16'hFFFF);
      end
      if (ack_fail) begin
`ifdef MSI_FAIL_RETRY_EN
`else
         if (!rereq_now) pend_d[cur_q] = 1'b0;
`endif
         last_d     = cur_q;
         fail_cnt_d = fail_cnt_q + 16'(fail_cnt_q != 16'hFFFF);
      end
   end

   assign ps_d = 32'(pend_q);
   assign de_d = (ps_d != ps_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= '0;
         cur_q      <= '0;
         last_q     <= IW'(MSI_COUNT - 1);
         tmr_q      <= '0;
         rereq_q    <= 1'b0;
         ps_q       <= '0;
         de_q       <= 1'b0;
         sent_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         tmr_q      <= tmr_d;
         rereq_q    <= rereq_d;
         ps_q       <= ps_d;
         de_q       <= de_d;
         sent_cnt_q <= sent_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign msi.cfg_interrupt_msi_select                      = '0;
   assign msi.cfg_interrupt_msi_function_number             = '0;
   assign msi.cfg_interrupt_msi_attr                        = '0;
   assign msi.cfg_interrupt_msi_tph_present                 = 1'b0;
   assign msi.cfg_interrupt_msi_tph_type                    = '0;
   assign msi.cfg_interrupt_msi_tph_st_tag                  = '0;
   assign msi.cfg_interrupt_msi_pending_status              = ps_q;
   assign msi.cfg_interrupt_msi_pending_status_data_enable  = de_q;
   assign msi.cfg_interrupt_msi_pending_status_function_num = '0;

   assign stat_sent_count_o = sent_cnt_q;
   assign stat_fail_count_o = fail_cnt_q;

   logic unused;
   assign unused = ^{msi.cfg_interrupt_msi_enable[3:1],
                     msi.cfg_interrupt_msi_mmenable[11:3]};
endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Directed bench for pcie_msi_irq_ctrl (TIMEOUT=16, 32 vectors).
// Expectations follow MSI_FAIL_RETRY_EN when it is defined.
module tb_pcie_msi_irq_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] irq = '0;
   logic [15:0] sent_cnt;
   logic [15:0] fail_cnt;
   logic [31:0] v;
   int          checks = 0;
   int          failures = 0;

   pcie_msi_irq_ctrl_if bus();

   pcie_msi_irq_ctrl #(.MSI_COUNT(32), .TIMEOUT(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .irq_in_i          (irq),
      .msi               (bus),
      .stat_sent_count_o (sent_cnt),
      .stat_fail_count_o (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_int(output logic [31:0] val);
      val = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.cfg_interrupt_msi_int != '0) begin
            val = bus.cfg_interrupt_msi_int;
            break;
         end
         tick();
      end
   endtask

   task automatic ack(input string tag, input logic [31:0] exp);
      logic [31:0] got;
      wait_int(got);
      chk(tag, got, exp);
      tick();
      bus.cfg_interrupt_msi_sent = 1'b1;
      tick();
      bus.cfg_interrupt_msi_sent = 1'b0;
   endtask

   task automatic pulse(input logic [31:0] bits);
      irq = bits;
      tick();
      irq = '0;
   endtask

   function automatic logic [31:0] consts();
      return 32'({bus.cfg_interrupt_msi_select,
                  bus.cfg_interrupt_msi_function_number,
                  bus.cfg_interrupt_msi_attr,
                  bus.cfg_interrupt_msi_tph_present,
                  bus.cfg_interrupt_msi_tph_type,
                  bus.cfg_interrupt_msi_tph_st_tag,
                  bus.cfg_interrupt_msi_pending_status_function_num});
   endfunction

   initial begin
      bus.cfg_interrupt_msi_enable   = 4'h0;
      bus.cfg_interrupt_msi_mmenable = 12'd0;
      bus.cfg_interrupt_msi_sent     = 1'b0;
      bus.cfg_interrupt_msi_fail     = 1'b0;
      repeat (3) tick();
      chk("rst_int", bus.cfg_interrupt_msi_int, 32'h0);
      chk("rst_ps", bus.cfg_interrupt_msi_pending_status, 32'h0);
      chk("rst_de", 32'(bus.cfg_interrupt_msi_pending_status_data_enable), 32'h0);
      chk("rst_sent", 32'(sent_cnt), 32'h0);
      chk("rst_fail", 32'(fail_cnt), 32'h0);
      chk("rst_consts", consts(), 32'h0);
      rst = 1'b0;
      bus.cfg_interrupt_msi_enable   = 4'h1;
      bus.cfg_interrupt_msi_mmenable = 12'd5;
      repeat (2) tick();

      // single vector, exact latency
      pulse(32'h8);
      chk("sv_idle", bus.cfg_interrupt_msi_int, 32'h0);
      tick();
      chk("sv_issue", bus.cfg_interrupt_msi_int, 32'h8);
      chk("sv_ps", bus.cfg_interrupt_msi_pending_status, 32'h8);
      chk("sv_de", 32'(bus.cfg_interrupt_msi_pending_status_data_enable), 32'h1);
      tick();
      chk("sv_one_cycle", bus.cfg_interrupt_msi_int, 32'h0);
      bus.cfg_interrupt_msi_sent = 1'b1;
      tick();
      bus.cfg_interrupt_msi_sent = 1'b0;
      chk("sv_sent_cnt", 32'(sent_cnt), 32'h1);
      tick();
      chk("sv_ps_clr", bus.cfg_interrupt_msi_pending_status, 32'h0);

      // folding with two granted messages
      bus.cfg_interrupt_msi_mmenable = 12'd1;
      pulse(32'h40);
      ack("fold_v6", 32'h1);
      pulse(32'h80);
      ack("fold_v7", 32'h2);
      bus.cfg_interrupt_msi_mmenable = 12'd7;

      // round robin order
      pulse(32'h13);
      ack("rr_0", 32'h1);
      ack("rr_1", 32'h2);
      ack("rr_4", 32'h10);

      // vector 0 held high competes fairly with 2 and 9
      irq = 32'h205;
      tick();
      irq = 32'h1;
      ack("cont_9", 32'h200);
      ack("cont_0a", 32'h1);
      ack("cont_2", 32'h4);
      ack("cont_0b", 32'h1);
      irq = '0;
      ack("cont_0c", 32'h1);
      repeat (2) tick();
      chk("cont_ps", bus.cfg_interrupt_msi_pending_status, 32'h0);
      chk("cont_sent", 32'(sent_cnt), 32'd11);

      // explicit fail
      pulse(32'h4);
      wait_int(v);
      chk("fail_issue", v, 32'h4);
      tick();
      bus.cfg_interrupt_msi_fail = 1'b1;
      tick();
      bus.cfg_interrupt_msi_fail = 1'b0;
      chk("fail_cnt", 32'(fail_cnt), 32'h1);
`ifdef MSI_FAIL_RETRY_EN
      ack("fail_retry", 32'h4);
`else
      repeat (2) tick();
      chk("fail_drop_ps", bus.cfg_interrupt_msi_pending_status, 32'h0);
`endif

      // timeout with no response
      pulse(32'h20);
      wait_int(v);
      chk("to_issue", v, 32'h20);
      repeat (16) tick();
      chk("to_last_wait", 32'(fail_cnt), 32'h1);
      tick();
      chk("to_exit", 32'(fail_cnt), 32'h2);
`ifdef MSI_FAIL_RETRY_EN
      ack("to_retry", 32'h20);
`else
      repeat (2) tick();
      chk("to_drop_ps", bus.cfg_interrupt_msi_pending_status, 32'h0);
`endif
      repeat (2) tick();

      // disabled: request is held but not issued
      bus.cfg_interrupt_msi_enable = 4'h0;
      pulse(32'h20);
      v = '0;
      repeat (6) begin
         if (bus.cfg_interrupt_msi_int != '0) v = bus.cfg_interrupt_msi_int;
         tick();
      end
      chk("dis_noint", v, 32'h0);
      chk("dis_ps", bus.cfg_interrupt_msi_pending_status, 32'h20);
      bus.cfg_interrupt_msi_enable = 4'h1;
      wait_int(v);
      chk("en_issue", v, 32'h20);

      // reset in WAIT, then a stale sent
      tick();
      rst = 1'b1;
      #1;
      chk("mr_int", bus.cfg_interrupt_msi_int, 32'h0);
      chk("mr_ps", bus.cfg_interrupt_msi_pending_status, 32'h0);
      chk("mr_sent", 32'(sent_cnt), 32'h0);
      chk("mr_fail", 32'(fail_cnt), 32'h0);
      tick();
      rst = 1'b0;
      bus.cfg_interrupt_msi_sent = 1'b1;
      tick();
      bus.cfg_interrupt_msi_sent = 1'b0;
      v = '0;
      repeat (4) begin
         if (bus.cfg_interrupt_msi_int != '0) v = bus.cfg_interrupt_msi_int;
         tick();
      end
      chk("late_noint", v, 32'h0);
      chk("late_sent", 32'(sent_cnt), 32'h0);
      chk("late_fail", 32'(fail_cnt), 32'h0);
      chk("late_ps", bus.cfg_interrupt_msi_pending_status, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
